crc_stream_engine: RTL
======================

CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, bus width in bits (multiple of 8, 8..32); CRC_WIDTH, default 32, CRC width (3..DATA_WIDTH); DEF_POLY, default 32'h04C11DB7, reset value of POLY; DEF_INIT, default 32'hFFFFFFFF, reset value of INIT; DEF_XOR, default 32'h0, reset value of XOROUT.
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 clock; reset_n in 1 reset; cs in 1 slave select; read in 1 read strobe; write in 1 write strobe; addr in 3 register address; write_data in DATA_WIDTH write data; read_data out DATA_WIDTH registered read data; waitrequest out 1 write stall; irq out 1 interrupt.
REQ-003 The block SHALL use one clock (clk); reset is asynchronous and active-low (reset_n).
REQ-004 Register map SHALL be: 0 DATA (W); 1 CTRL (R/W); 2 STATUS (R, W1C); 3 RESULT (R); 4 POLY (R/W); 5 INIT (R/W); 6 XOROUT (R/W); 7 reserved (reads 0, writes ignored).
REQ-005 CTRL fields SHALL be: bit0 START (write-only, self-clearing, reads 0); bit1 REFIN; bit2 REFOUT; bit3 IRQ_EN; bits[10:8] LAST_BYTES (0 = all DATA_WIDTH/8 bytes valid, n = n most-significant bytes valid).
REQ-006 STATUS fields SHALL be: bit0 BUSY; bit1 DONE; bit2 IRQ_PEND (write 1 clears).

Function
REQ-007 read_data SHALL update on the clk edge where cs&read is sampled (1-cycle latency) and hold otherwise; reads SHALL never stall.
REQ-008 POLY/INIT/XOROUT/RESULT SHALL use CRC_WIDTH LSBs; unused read bits SHALL read 0.
REQ-009 FSM SHALL have states IDLE and BUSY; BUSY asserts STATUS.BUSY.
REQ-010 Writing CTRL with START=1 in IDLE SHALL load crc <- INIT, clear DONE, and update REFIN/REFOUT/IRQ_EN/LAST_BYTES in the same cycle.
REQ-011 A DATA write in IDLE SHALL latch the word, set byte count = LAST_BYTES (or DATA_WIDTH/8 if 0), clear DONE, and enter BUSY next cycle.
REQ-012 BUSY SHALL process one byte per cycle, most-significant valid byte first; REFIN=1 reverses bit order within each byte before processing.
REQ-013 Per byte, 8 bit-steps MSB-first: fb = crc[CRC_WIDTH-1] ^ bit; crc = (crc << 1) ^ (fb ? POLY : 0), truncated to CRC_WIDTH.
REQ-014 After the last byte, the FSM SHALL return to IDLE and set DONE; BUSY lasts exactly byte-count cycles.
REQ-015 RESULT SHALL read (REFOUT ? bitreverse(crc) : crc) ^ XOROUT, combinational on current state, zero-extended.
REQ-016 Successive DATA writes without START SHALL continue from the current crc (multi-word messages).
REQ-017 waitrequest SHALL be asserted combinationally while BUSY for cs&write to any address except STATUS; the stalled write SHALL complete in the first IDLE cycle, not be dropped.
REQ-018 DONE rising with IRQ_EN=1 SHALL set IRQ_PEND; irq = IRQ_PEND & IRQ_EN.
REQ-019 If a STATUS W1C and a DONE rise occur in the same cycle, IRQ_PEND SHALL remain set.
REQ-020 Writes to POLY/INIT/XOROUT in IDLE SHALL take effect at the next START or DATA write.
REQ-021 LAST_BYTES values > DATA_WIDTH/8 SHALL be treated as DATA_WIDTH/8.

Reset
REQ-022 On reset_n low, outputs and state SHALL clear asynchronously: read_data=0, waitrequest=0, irq=0, FSM=IDLE, crc=DEF_INIT, POLY=DEF_POLY, INIT=DEF_INIT, XOROUT=DEF_XOR, CTRL=0, STATUS=0.
REQ-023 Reset asserted mid-BUSY SHALL abort the message; no DONE or irq SHALL follow its release.

Verification
REQ-024 CRC-32/MPEG-2 (defaults, REFIN=REFOUT=0): START; DATA 0x31323334, 0x35363738; CTRL LAST_BYTES=1; DATA 0x39000000 -> RESULT=0x0376E6E7, DONE=1.
REQ-025 CRC-32: XOROUT=0xFFFFFFFF, START with REFIN=REFOUT=1, same data -> RESULT=0xCBF43926.
REQ-026 Back-to-back DATA writes -> second write sees waitrequest high for 4 cycles, then accepted; BUSY high 4 cycles per word.
REQ-027 IRQ_EN=1, one word -> irq rises with DONE; write STATUS 0x4 -> irq=0 next cycle; simultaneous W1C and DONE -> irq stays 1.
REQ-028 reset_n low on 2nd BUSY cycle -> all registers at REQ-022 values immediately; no DONE after release.
REQ-029 CRC_WIDTH=8, POLY=0x07, INIT=0, 9 bytes "123456789" as in REQ-024 -> RESULT=0xF4.

Source files
------------

// File: rtl/crc_stream_engine.sv
// Register-mapped CRC engine: each DATA word is latched and folded into the running
// CRC one byte per clock, most-significant valid byte first.
module crc_stream_engine #(
    parameter int          DATA_WIDTH = 32,
    parameter int          CRC_WIDTH  = 32,
    parameter logic [31:0] DEF_POLY   = 32'h04C11DB7,
    parameter logic [31:0] DEF_INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] DEF_XOR    = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cs,
    input  logic                  read,
    input  logic                  write,
    input  logic [2:0]            addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  waitrequest,
    output logic                  irq
);
    localparam int         BYTES   = DATA_WIDTH / 8;
    localparam logic [2:0] BYTES_L = 3'(BYTES);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_RESULT = 3'd3;
    localparam logic [2:0] ADDR_POLY   = 3'd4;
    localparam logic [2:0] ADDR_INIT   = 3'd5;
    localparam logic [2:0] ADDR_XOROUT = 3'd6;

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state_q, state_d;

    logic [CRC_WIDTH-1:0]  crc_q, poly_q, init_q, xorout_q, result;
    logic [DATA_WIDTH-1:0] data_q;
    logic [2:0]            byte_cnt_q, last_bytes_q, byte_cnt_eff;
    logic                  refin_q, refout_q, irq_en_q, done_q, irq_pend_q;
    logic [31:0]           wd32, rd_mux;
    logic [7:0]            cur_byte;
    logic                  wr_acc, status_clr, done_rise;
    logic                  unused_wd;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r, s;
        r = '0;
        s = b;
        for (int i = 0; i < 8; i++) begin
            r = {r[6:0], s[0]};
            s = s >> 1;
        end
        return r;
    endfunction

    function automatic logic [CRC_WIDTH-1:0] rev_crc(input logic [CRC_WIDTH-1:0] c);
        logic [CRC_WIDTH-1:0] r, s;
        r = '0;
        s = c;
        for (int i = 0; i < CRC_WIDTH; i++) begin
            r = {r[CRC_WIDTH-2:0], s[0]};
            s = s >> 1;
        end
        return r;
    endfunction

    // Eight MSB-first shift steps of the generic (non-reflected) CRC recurrence.
    function automatic logic [CRC_WIDTH-1:0] crc_byte(input logic [CRC_WIDTH-1:0] c_in,
                                                      input logic [7:0]           b_in,
                                                      input logic [CRC_WIDTH-1:0] p);
        logic [CRC_WIDTH-1:0] c;
        logic [7:0]           b;
        logic                 fb;
        c = c_in;
        b = b_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[CRC_WIDTH-1] ^ b[7];
            c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? p : '0);
            b  = b << 1;
        end
        return c;
    endfunction

    assign wd32         = 32'(write_data);
    assign unused_wd    = ^{wd32[31:11], wd32[7:4]};
    assign waitrequest  = (state_q == BUSY) && cs && write && (addr != ADDR_STATUS);
    assign wr_acc       = cs && write && !waitrequest;
    assign status_clr   = wr_acc && (addr == ADDR_STATUS) && wd32[2];
    assign done_rise    = (state_q == BUSY) && (byte_cnt_q == 3'd1);
    assign byte_cnt_eff = (last_bytes_q == 3'd0 || last_bytes_q > BYTES_L) ? BYTES_L : last_bytes_q;
    assign cur_byte     = data_q[DATA_WIDTH-1 -: 8];
    assign result       = (refout_q ? rev_crc(crc_q) : crc_q) ^ xorout_q;
    assign irq          = irq_pend_q & irq_en_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (wr_acc && addr == ADDR_DATA) state_d = BUSY;
            BUSY: if (byte_cnt_q == 3'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_CTRL:   rd_mux = {21'd0, last_bytes_q, 4'd0, irq_en_q, refout_q, refin_q, 1'b0};
            ADDR_STATUS: rd_mux = {29'd0, irq_pend_q, done_q, state_q == BUSY};
            ADDR_RESULT: rd_mux = 32'(result);
            ADDR_POLY:   rd_mux = 32'(poly_q);
            ADDR_INIT:   rd_mux = 32'(init_q);
            ADDR_XOROUT: rd_mux = 32'(xorout_q);
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data    <= '0;
            crc_q        <= DEF_INIT[CRC_WIDTH-1:0];
            poly_q       <= DEF_POLY[CRC_WIDTH-1:0];
            init_q       <= DEF_INIT[CRC_WIDTH-1:0];
            xorout_q     <= DEF_XOR[CRC_WIDTH-1:0];
            data_q       <= '0;
            byte_cnt_q   <= '0;
            last_bytes_q <= '0;
            refin_q      <= 1'b0;
            refout_q     <= 1'b0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            irq_pend_q   <= 1'b0;
        end else begin
            if (cs && read) read_data <= rd_mux[DATA_WIDTH-1:0];

            // Only STATUS can be accepted while BUSY, so the rest only land in IDLE.
            if (wr_acc) begin
                case (addr)
                    ADDR_DATA: begin
                        data_q     <= write_data;
                        byte_cnt_q <= byte_cnt_eff;
                        done_q     <= 1'b0;
                    end
                    ADDR_CTRL: begin
                        refin_q      <= wd32[1];
                        refout_q     <= wd32[2];
                        irq_en_q     <= wd32[3];
                        last_bytes_q <= wd32[10:8];
                        if (wd32[0]) begin
                            crc_q  <= init_q;
                            done_q <= 1'b0;
                        end
                    end
                    ADDR_POLY:   poly_q   <= write_data[CRC_WIDTH-1:0];
                    ADDR_INIT:   init_q   <= write_data[CRC_WIDTH-1:0];
                    ADDR_XOROUT: xorout_q <= write_data[CRC_WIDTH-1:0];
                    default: ;
                endcase
            end

            if (state_q == BUSY) begin
                crc_q      <= crc_byte(crc_q, refin_q ? rev8(cur_byte) : cur_byte, poly_q);
                data_q     <= data_q << 8;
                byte_cnt_q <= byte_cnt_q - 3'd1;
                if (done_rise) done_q <= 1'b1;
            end

            // A completion in the same cycle as a W1C wins.
            irq_pend_q <= (done_rise && irq_en_q) || (irq_pend_q && !status_clr);
        end
    end
endmodule
